pe_compare_pipe: RTL and testbench

PE_COMPARE_PIPE -- requirements
Module: pe_compare_pipe

---
 rtl/pe_compare_pkg.sv | 14 +
 rtl/pe_compare_core.sv | 42 ++++
 rtl/pe_compare_pipe.sv | 109 ++++++++++
 tb/tb_pe_compare_pipe.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_compare_pkg.sv
// Shared types for the compare pipeline: op encoding and counter width.
// Imported by pe_compare_core and pe_compare_pipe.
package pe_compare_pkg;

    typedef enum logic [1:0] {
        CMP_LT = 2'b00,
        CMP_LE = 2'b01,
        CMP_EQ = 2'b10,
        CMP_NE = 2'b11
    } cmp_op_e;

    localparam int TRUE_CNT_W = 16;

endpackage

// File: rtl/pe_compare_core.sv
// Combinational comparator: pred = (a op b), signed or unsigned.
// Ports: a, b operands; op compare kind; is_signed; pred result bit.
module pe_compare_core
    import pe_compare_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  cmp_op_e          op,
    input  logic             is_signed,
    output logic             pred
);

    logic [WIDTH-1:0] a_k;
    logic [WIDTH-1:0] b_k;
    logic             lt;
    logic             eq;

    // Flipping the sign bit maps two's complement order onto
    // unsigned order, so one magnitude comparator serves both.
    always_comb begin
        a_k            = a;
        b_k            = b;
        a_k[WIDTH-1]   = a[WIDTH-1] ^ is_signed;
        b_k[WIDTH-1]   = b[WIDTH-1] ^ is_signed;
        lt             = (a_k < b_k);
        eq             = (a == b);
    end

    always_comb begin
        pred = 1'b0;
        unique case (op)
            CMP_LT: pred = lt;
            CMP_LE: pred = lt | eq;
            CMP_EQ: pred = eq;
            CMP_NE: pred = ~eq;
            default: pred = 1'b0;
        endcase
    end

endmodule

// File: rtl/pe_compare_pipe.sv
// Two-stage valid/ready compare pipeline with a count of true results.
// Ports: UserCLK, rst (async high); in_valid/in_ready, A, B, op,
// is_signed in; out_valid/out_ready, Y (zero-extended pred), true_count.
module pe_compare_pipe
    import pe_compare_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 32
) (
    input  logic                  UserCLK,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      A,
    input  logic [WIDTH-1:0]      B,
    input  logic [1:0]            op,
    input  logic                  is_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  Y,
    output logic [TRUE_CNT_W-1:0] true_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    cmp_op_e          s1_op;
    logic             s1_sgn;

    logic             s2_valid;
    logic             s2_pred;

    logic             core_pred;
    logic             deliver;
    logic             s1_move;
    logic             accept;

    logic [TRUE_CNT_W-1:0] cnt_q;

    // S2 frees up when empty or being drained this cycle; S1 likewise
    // when empty or moving forward. in_ready never looks at in_valid.
    always_comb begin
        deliver  = s2_valid & out_ready;
        s1_move  = s1_valid & (~s2_valid | out_ready);
        in_ready = ~rst & (~s1_valid | s1_move);
        accept   = in_valid & in_ready;
    end

    always_ff @(posedge UserCLK or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= CMP_LT;
            s1_sgn   <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= A;
                s1_b     <= B;
                s1_op    <= cmp_op_e'(op);
                s1_sgn   <= is_signed;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end
        end
    end

    pe_compare_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a         (s1_a),
        .b         (s1_b),
        .op        (s1_op),
        .is_signed (s1_sgn),
        .pred      (core_pred)
    );

    always_ff @(posedge UserCLK or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_pred  <= 1'b0;
        end else begin
            if (s1_move) begin
                s2_valid <= 1'b1;
                s2_pred  <= core_pred;
            end else if (deliver) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // Counter wraps naturally at its width.
    always_ff @(posedge UserCLK or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (deliver && s2_pred) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        Y          = '0;
        Y[0]       = s2_pred;
        out_valid  = s2_valid;
        true_count = cnt_q;
    end

endmodule

// File: tb/tb_pe_compare_pipe.sv
// Scoreboard bench for pe_compare_pipe: expected predicates are queued
// on acceptance and compared on delivery; tasks cover each scenario.
module tb_pe_compare_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  op;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Y;
    logic [15:0] true_count;

    int passed;
    int total;
    int cyc;
    int n_deliv;
    int exp_cnt;
    bit sb[$];
    int dcyc[$];
    bit dval[$];

    pe_compare_pipe #(
        .WIDTH(32),
        .OUT_WIDTH(32)
    ) dut (
        .UserCLK    (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .op         (op),
        .is_signed  (is_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Y          (Y),
        .true_count (true_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic bit model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] o, input logic s);
        bit lt;
        if (s) lt = ($signed(a) < $signed(b));
        else   lt = (a < b);
        case (o)
            2'b00:   return lt;
            2'b01:   return lt || (a == b);
            2'b10:   return (a == b);
            default: return (a != b);
        endcase
    endfunction

    // Scoreboard: pop on delivery first, then push the newly accepted beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                logic [31:0] e;
                bit          x;
                n_deliv++;
                dcyc.push_back(cyc);
                dval.push_back(Y[0]);
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_spurious Y=%0h required no output", Y);
                end else begin
                    x    = sb.pop_front();
                    e    = '0;
                    e[0] = x;
                    if (Y !== e)
                        $display("FAIL sb_result Y=%0h required %0h", Y, e);
                    else
                        passed++;
                    if (x) exp_cnt++;
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(A, B, op, is_signed));
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] o, input logic s);
        A         = a;
        B         = b;
        op        = o;
        is_signed = s;
        in_valid  = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 200)
            $display("FAIL drain_timeout pending=%0d required 0", sb.size());
        else
            passed++;
    endtask

    task automatic stream(input int n, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] o,
                          input logic s);
        int acc;
        int lim;
        acc = 0;
        lim = 0;
        @(posedge clk);
        #1;
        drive(a, b, o, s);
        while (acc < n && lim < n + 100) begin
            @(negedge clk);
            if (in_ready) acc++;
            lim++;
            if (acc < n) @(posedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (acc != n)
            $display("FAIL stream_accept got=%0d required %0d", acc, n);
        else
            passed++;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A = '0; B = '0; op = 2'b00; is_signed = 1'b0;
        #2 rst = 1'b1;
        #1;
        total += 4;
        if (out_valid !== 1'b0)
            $display("FAIL rst_out_valid got=%b required 0", out_valid);
        else passed++;
        if (Y !== 32'h0)
            $display("FAIL rst_Y got=%0h required 0", Y);
        else passed++;
        if (true_count !== 16'h0)
            $display("FAIL rst_true_count got=%0h required 0", true_count);
        else passed++;
        if (in_ready !== 1'b0)
            $display("FAIL rst_in_ready got=%b required 0", in_ready);
        else passed++;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL post_rst_in_ready got=%b required 1", in_ready);
        else passed++;
    endtask

    task automatic test_basic();
        @(posedge clk);
        #1 drive(32'd5, 32'd7, 2'b00, 1'b0);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL basic_accept in_ready=%b required 1", in_ready);
        else passed++;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL basic_lat1 out_valid=%b required 0", out_valid);
        else passed++;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || Y !== 32'h1)
            $display("FAIL basic_lat2 out_valid=%b Y=%0h required 1/1",
                     out_valid, Y);
        else passed++;
        drain();
        total++;
        if (true_count !== 16'd1)
            $display("FAIL basic_count got=%0d required 1", true_count);
        else passed++;
    endtask

    task automatic test_signed();
        int d0;
        d0 = n_deliv;
        stream(1, 32'hFFFF_FFFF, 32'd1, 2'b00, 1'b1);
        stream(1, 32'hFFFF_FFFF, 32'd1, 2'b00, 1'b0);
        drain();
        total++;
        if (n_deliv - d0 != 2 || dval.size() < 2 ||
            dval[dval.size()-2] !== 1'b1 || dval[dval.size()-1] !== 1'b0)
            $display("FAIL signed_lt deliveries=%0d required 2 as 1,0",
                     n_deliv - d0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta[4] = '{32'd3, 32'd3, 32'd4, 32'd4};
        logic [1:0]  to[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        bit          ev[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int          rdy_bad;
        rdy_bad = 0;
        dcyc.delete();
        dval.delete();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 drive(ta[i], ta[i], to[i], 1'b0);
            @(negedge clk);
            if (in_ready !== 1'b1) rdy_bad++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        total++;
        if (rdy_bad != 0)
            $display("FAIL b2b_in_ready low_cycles=%0d required 0", rdy_bad);
        else passed++;
        total++;
        if (dcyc.size() != 4)
            $display("FAIL b2b_count got=%0d required 4", dcyc.size());
        else if (dcyc[1] != dcyc[0] + 1 || dcyc[2] != dcyc[0] + 2 ||
                 dcyc[3] != dcyc[0] + 3)
            $display("FAIL b2b_spacing got=%0d,%0d,%0d,%0d required consecutive",
                     dcyc[0], dcyc[1], dcyc[2], dcyc[3]);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= dval.size() || dval[i] !== ev[i])
                $display("FAIL b2b_val%0d got=%b required %b", i,
                         (i < dval.size()) ? dval[i] : 1'bx, ev[i]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ba[3] = '{32'hFFFF_FFFE, 32'd5, 32'd5};
        logic [31:0] bb[3] = '{32'd2, 32'd6, 32'd6};
        logic [1:0]  bo[3] = '{2'b00, 2'b10, 2'b11};
        int          idx;
        int          d0;
        int          lim;
        bit          seen;
        logic [31:0] y0;
        idx = 0;
        seen = 1'b0;
        y0 = '0;
        d0 = n_deliv;
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(posedge clk);
            #1 drive(ba[idx], bb[idx], bo[idx], 1'b1);
            @(negedge clk);
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    y0 = Y;
                end else begin
                    total++;
                    if (Y !== y0 || out_valid !== 1'b1)
                        $display("FAIL bp_stable Y=%0h required %0h", Y, y0);
                    else passed++;
                end
            end
            if (in_ready) idx++;
        end
        total += 2;
        if (idx != 2)
            $display("FAIL bp_accepted got=%0d required 2", idx);
        else passed++;
        if (in_ready !== 1'b0)
            $display("FAIL bp_in_ready got=%b required 0", in_ready);
        else passed++;
        total++;
        if (n_deliv != d0)
            $display("FAIL bp_no_delivery got=%0d required 0", n_deliv - d0);
        else passed++;
        @(posedge clk);
        #1 out_ready = 1'b1;
        lim = 0;
        while (idx < 3 && lim < 20) begin
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk);
            #1;
            lim++;
        end
        in_valid = 1'b0;
        drain();
        total++;
        if (n_deliv - d0 != 3 || dval.size() < 3 ||
            dval[dval.size()-3] !== 1'b1 || dval[dval.size()-2] !== 1'b0 ||
            dval[dval.size()-1] !== 1'b1)
            $display("FAIL bp_order deliveries=%0d required 3 as 1,0,1",
                     n_deliv - d0);
        else passed++;
    endtask

    task automatic test_wrap();
        int n;
        n = 16'hFFFF - exp_cnt;
        stream(n, 32'd1, 32'd2, 2'b00, 1'b0);
        drain();
        total++;
        if (true_count !== 16'hFFFF)
            $display("FAIL wrap_pre got=%0h required ffff", true_count);
        else passed++;
        stream(1, 32'd9, 32'd9, 2'b10, 1'b0);
        drain();
        total++;
        if (true_count !== 16'h0000)
            $display("FAIL wrap_post got=%0h required 0", true_count);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int ov;
        int d0;
        @(posedge clk);
        #1 out_ready = 1'b0;
        stream(2, 32'd1, 32'd2, 2'b00, 1'b0);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL rm_full out_valid=%b in_ready=%b required 1/0",
                     out_valid, in_ready);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total += 3;
        if (out_valid !== 1'b0)
            $display("FAIL rm_out_valid got=%b required 0", out_valid);
        else passed++;
        if (Y !== 32'h0)
            $display("FAIL rm_Y got=%0h required 0", Y);
        else passed++;
        if (in_ready !== 1'b0)
            $display("FAIL rm_in_ready got=%b required 0", in_ready);
        else passed++;
        sb.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        d0 = n_deliv;
        ov = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) ov++;
        end
        total++;
        if (ov != 0)
            $display("FAIL rm_spurious out_valid_cycles=%0d required 0", ov);
        else passed++;
        stream(1, 32'd0, 32'd1, 2'b01, 1'b0);
        drain();
        total++;
        if (n_deliv - d0 != 1 || true_count !== 16'd1)
            $display("FAIL rm_resume deliveries=%0d count=%0d required 1/1",
                     n_deliv - d0, true_count);
        else passed++;
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        cyc     = 0;
        n_deliv = 0;
        exp_cnt = 0;
        test_reset();
        test_basic();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
